// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-port signals of mem_port_arbiter.
// master = the arbiter itself; slave = the core requesters plus the memory.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic              i_req;
   logic [AW-1:0]     i_addr;
   logic              i_ack;
   logic [DW-1:0]     i_rdata;
   logic              d_req;
   logic              d_we;
   logic [AW-1:0]     d_addr;
   logic [DW-1:0]     d_wdata;
   logic [DW/8-1:0]   d_wstrb;
   logic              d_ack;
   logic [DW-1:0]     d_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW/8-1:0]   mem_wstrb;
   logic              mem_ack;
   logic [DW-1:0]     mem_rdata;
   logic              timeout_err;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             mem_wstrb, timeout_err
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             mem_wstrb, timeout_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D) with a no-ack watchdog.
// Define MEM_ARB_ROUND_ROBIN_EN to break simultaneous requests by last_grant instead of D priority.
//
// state   | meaning
// IDLE    | no access outstanding; arbitrate incoming requests
// GRANT_I | fetch access on the memory port, waiting for mem_ack or watchdog
// GRANT_D | load/store access on the memory port, waiting for mem_ack or watchdog
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input logic clk,
   input logic reset,
   mem_port_arbiter_if.master bus
);
   localparam int SW = DW / 8;
   localparam logic [7:0] WDOG_TC = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

   state_t          state_q, state_d;
   logic [7:0]      wdog_q, wdog_d;
   logic            last_grant_q, last_grant_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;
   logic            i_ack_q, i_ack_d;
   logic            d_ack_q, d_ack_d;
   logic [DW-1:0]   i_rdata_q, i_rdata_d;
   logic [DW-1:0]   d_rdata_q, d_rdata_d;
   logic            terr_q, terr_d;
   logic            req_i, req_d, pick_d;

   // A side whose ack is on the wire is still holding its request; do not re-grant it.
   assign req_i = bus.i_req & ~i_ack_q;
   assign req_d = bus.d_req & ~d_ack_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   assign pick_d = req_d & (~req_i | ~last_grant_q);
`else
   logic last_grant_unused;
   assign pick_d            = req_d;
   assign last_grant_unused = last_grant_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         wdog_q       <= '0;
         last_grant_q <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         terr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wdog_q       <= wdog_d;
         last_grant_q <= last_grant_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         terr_q       <= terr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wdog_d       = wdog_q;
      last_grant_d = last_grant_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wstrb_d  = mem_wstrb_q;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      terr_d       = terr_q;
      case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d      = GRANT_D;
               wdog_d       = '0;
               last_grant_d = 1'b1;
               mem_req_d    = 1'b1;
               mem_we_d     = bus.d_we;
               mem_addr_d   = bus.d_addr;
               mem_wdata_d  = bus.d_wdata;
               mem_wstrb_d  = bus.d_wstrb;
            end else if (req_i) begin
               state_d      = GRANT_I;
               wdog_d       = '0;
               last_grant_d = 1'b0;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = bus.i_addr;
               mem_wdata_d  = '0;
               mem_wstrb_d  = '0;
            end
         end
         GRANT_I, GRANT_D: begin
            // mem_ack takes precedence over a watchdog expiry in the same cycle.
            if (bus.mem_ack || wdog_q == WDOG_TC) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (!bus.mem_ack)
                  terr_d = 1'b1;
               if (state_q == GRANT_I) begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
               end else begin
                  d_ack_d = 1'b1;
                  if (!bus.mem_ack)
                     d_rdata_d = '0;
                  else if (!mem_we_q)
                     d_rdata_d = bus.mem_rdata;
               end
            end else begin
               wdog_d = wdog_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.mem_wstrb   = mem_wstrb_q;
   assign bus.i_ack       = i_ack_q;
   assign bus.d_ack       = d_ack_q;
   assign bus.i_rdata     = i_rdata_q;
   assign bus.d_rdata     = d_rdata_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard queues of expected read data, popped on each ack.
// Instance A (TIMEOUT=8) runs the main sequence; instance B (TIMEOUT=4) covers idle acks and the ack/timeout collision.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int TO_A = 8;
   localparam int TO_B = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) a ();
   mem_port_arbiter_if #(.AW(AW), .DW(DW)) b ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO_A)) dut_a (.clk(clk), .reset(rst), .bus(a));
   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO_B)) dut_b (.clk(clk), .reset(rst), .bus(b));

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_i[$];
   logic [31:0] exp_d[$];
   byte         ack_log[$];
   int          cyc = 0;
   int          i_ack_cyc = 0;
   int          d_ack_cyc = 0;
   logic        prev_i = 1'b0;
   logic        prev_d = 1'b0;
   int          mem_lat = 0;
   int          wait_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] addr);
      if (addr == 32'h10) return 32'h0050_0093;
      return {addr[15:0], 16'hC0DE} ^ 32'h5A00_0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drops each request once its ack is seen; returns the number of edges taken.
   task automatic run_until_done(input int budget, output int ticks);
      ticks = 0;
      while ((a.i_req || a.d_req) && ticks < budget) begin
         tick();
         ticks++;
         if (a.i_ack) a.i_req = 1'b0;
         if (a.d_ack) a.d_req = 1'b0;
      end
      check("acks_within_budget", {62'd0, a.i_req, a.d_req}, 64'd0);
      a.i_req = 1'b0;
      a.d_req = 1'b0;
   endtask

   // Memory model for instance A: acks after mem_lat extra cycles, never if mem_lat < 0.
   initial begin
      a.mem_ack   = 1'b0;
      a.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         a.mem_ack   = 1'b0;
         a.mem_rdata = '0;
         if (a.mem_req && mem_lat >= 0) begin
            if (wait_cnt == mem_lat) begin
               a.mem_ack   = 1'b1;
               a.mem_rdata = mem_fn(a.mem_addr);
               wait_cnt    = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Ack monitor: every ack must be expected, one cycle wide, and carry the queued data.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (a.i_ack) begin
            check("i_ack_width", {63'd0, prev_i}, 64'd0);
            check("i_ack_expected", {63'd0, exp_i.size() != 0}, 64'd1);
            if (exp_i.size() != 0) check("i_rdata", a.i_rdata, exp_i.pop_front());
            ack_log.push_back("I");
            i_ack_cyc = cyc;
         end
         if (a.d_ack) begin
            check("d_ack_width", {63'd0, prev_d}, 64'd0);
            check("d_ack_expected", {63'd0, exp_d.size() != 0}, 64'd1);
            if (exp_d.size() != 0) check("d_rdata", a.d_rdata, exp_d.pop_front());
            ack_log.push_back("D");
            d_ack_cyc = cyc;
         end
         prev_i = a.i_ack;
         prev_d = a.d_ack;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int          t;
      int          n;
      byte         first;
      logic [31:0] d_model;

      rst = 1'b1;
      a.i_req = 1'b0; a.i_addr = '0; a.d_req = 1'b0; a.d_we = 1'b0;
      a.d_addr = '0; a.d_wdata = '0; a.d_wstrb = '0;
      b.i_req = 1'b0; b.i_addr = '0; b.d_req = 1'b0; b.d_we = 1'b0;
      b.d_addr = '0; b.d_wdata = '0; b.d_wstrb = '0;
      b.mem_ack = 1'b0; b.mem_rdata = '0;
      d_model = '0;
      repeat (3) tick();

      check("rst_i_ack", {63'd0, a.i_ack}, 64'd0);
      check("rst_d_ack", {63'd0, a.d_ack}, 64'd0);
      check("rst_i_rdata", a.i_rdata, 64'd0);
      check("rst_d_rdata", a.d_rdata, 64'd0);
      check("rst_mem_req", {63'd0, a.mem_req}, 64'd0);
      check("rst_mem_we", {63'd0, a.mem_we}, 64'd0);
      check("rst_mem_addr", a.mem_addr, 64'd0);
      check("rst_mem_wdata", a.mem_wdata, 64'd0);
      check("rst_mem_wstrb", a.mem_wstrb, 64'd0);
      check("rst_timeout_err", {63'd0, a.timeout_err}, 64'd0);
      rst = 1'b0;
      tick();

      // Single fetch, memory acks in its 4th request cycle.
      mem_lat = 3;
      exp_i.push_back(32'h0050_0093);
      a.i_addr = 32'h10;
      a.i_req  = 1'b1;
      tick();
      check("fetch_mem_req", {63'd0, a.mem_req}, 64'd1);
      check("fetch_mem_we", {63'd0, a.mem_we}, 64'd0);
      check("fetch_mem_addr", a.mem_addr, 64'h10);
      check("fetch_mem_wstrb", a.mem_wstrb, 64'd0);
      run_until_done(20, t);
      check("fetch_latency", t + 1, 64'd5);
      tick();

      // Zero-wait load: ack two edges after the request.
      mem_lat = 0;
      d_model = mem_fn(32'h200);
      exp_d.push_back(d_model);
      a.d_we = 1'b0; a.d_addr = 32'h200; a.d_req = 1'b1;
      run_until_done(20, t);
      check("load_latency", t, 64'd2);
      tick();

      // Store: address and strobes held until ack, d_rdata keeps the last load value.
      mem_lat = 2;
      exp_d.push_back(d_model);
      a.d_we = 1'b1; a.d_addr = 32'h100; a.d_wdata = 32'hDEAD_BEEF; a.d_wstrb = 4'b0011;
      a.d_req = 1'b1;
      tick();
      check("st_mem_we", {63'd0, a.mem_we}, 64'd1);
      check("st_mem_wdata", a.mem_wdata, 64'hDEAD_BEEF);
      for (int k = 0; k < 20 && !a.d_ack; k++) begin
         check("st_addr_hold", a.mem_addr, 64'h100);
         check("st_wstrb_hold", a.mem_wstrb, 64'h3);
         check("st_req_hold", {63'd0, a.mem_req}, 64'd1);
         tick();
      end
      check("st_acked", {63'd0, a.d_ack}, 64'd1);
      a.d_req = 1'b0;
      a.d_we  = 1'b0;
      tick();

      // Contention with zero-wait memory; last grant so far was D.
      mem_lat = 0;
      ack_log.delete();
      d_model = mem_fn(32'h80);
      exp_i.push_back(mem_fn(32'h40));
      exp_d.push_back(d_model);
      a.i_addr = 32'h40; a.d_addr = 32'h80;
      a.i_req = 1'b1; a.d_req = 1'b1;
      run_until_done(20, t);
      tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      first = "I";
`else
      first = "D";
`endif
      check("cont_ack_count", ack_log.size(), 64'd2);
      if (ack_log.size() == 2) check("cont_first", {56'd0, ack_log[0]}, {56'd0, first});
      if (first == "D") check("cont_gap", i_ack_cyc - d_ack_cyc, 64'd2);
      else              check("cont_gap", d_ack_cyc - i_ack_cyc, 64'd2);

      // Watchdog: memory never acks a fetch.
      mem_lat = -1;
      exp_i.push_back(32'h0);
      a.i_addr = 32'h20;
      a.i_req  = 1'b1;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (a.i_ack) break;
         check("to_req_held", {63'd0, a.mem_req}, 64'd1);
         check("to_err_before", {63'd0, a.timeout_err}, 64'd0);
         n++;
      end
      check("to_grant_cycles", n, TO_A);
      check("to_err_set", {63'd0, a.timeout_err}, 64'd1);
      check("to_mem_req_drop", {63'd0, a.mem_req}, 64'd0);
      a.i_req = 1'b0;
      repeat (2) tick();
      check("to_err_sticky", {63'd0, a.timeout_err}, 64'd1);

      // Load after a timeout completes normally.
      mem_lat = 1;
      d_model = mem_fn(32'h300);
      exp_d.push_back(d_model);
      a.d_addr = 32'h300; a.d_req = 1'b1;
      run_until_done(20, t);
      check("post_to_load_latency", t, 64'd3);
      check("post_to_err_sticky", {63'd0, a.timeout_err}, 64'd1);
      tick();

      // Reset two cycles before the memory would ack a load: no ack, outputs back to 0.
      mem_lat = 3;
      a.d_addr = 32'h400; a.d_req = 1'b1;
      tick();
      tick();
      check("mr_mem_req_before", {63'd0, a.mem_req}, 64'd1);
      rst = 1'b1;
      #1;
      check("mr_mem_req", {63'd0, a.mem_req}, 64'd0);
      check("mr_mem_addr", a.mem_addr, 64'd0);
      check("mr_d_rdata", a.d_rdata, 64'd0);
      check("mr_timeout_err", {63'd0, a.timeout_err}, 64'd0);
      a.d_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("mr_no_req", {63'd0, a.mem_req}, 64'd0);
         check("mr_no_d_ack", {63'd0, a.d_ack}, 64'd0);
      end
      mem_lat = 0;
      exp_i.push_back(mem_fn(32'h10));
      a.i_addr = 32'h10; a.i_req = 1'b1;
      run_until_done(20, t);
      check("mr_fetch_latency", t, 64'd2);
      tick();

      // Instance B: mem_ack while idle is ignored.
      b.mem_ack = 1'b1; b.mem_rdata = 32'hFFFF_0000;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("idle_ack_no_i_ack", {63'd0, b.i_ack}, 64'd0);
         check("idle_ack_no_d_ack", {63'd0, b.d_ack}, 64'd0);
         check("idle_ack_no_req", {63'd0, b.mem_req}, 64'd0);
      end
      b.mem_ack = 1'b0;
      tick();

      // Instance B: mem_ack on the last watchdog cycle wins.
      b.i_addr = 32'h50; b.i_req = 1'b1;
      repeat (4) tick();
      check("col_req_held", {63'd0, b.mem_req}, 64'd1);
      check("col_no_early_ack", {63'd0, b.i_ack}, 64'd0);
      b.mem_ack = 1'b1; b.mem_rdata = 32'h1234_5678;
      tick();
      check("col_i_ack", {63'd0, b.i_ack}, 64'd1);
      check("col_i_rdata", b.i_rdata, 64'h1234_5678);
      check("col_timeout_err", {63'd0, b.timeout_err}, 64'd0);
      check("col_mem_req_drop", {63'd0, b.mem_req}, 64'd0);
      b.mem_ack = 1'b0; b.i_req = 1'b0;
      tick();
      check("col_ack_pulse", {63'd0, b.i_ack}, 64'd0);
      check("col_timeout_err_after", {63'd0, b.timeout_err}, 64'd0);

      repeat (3) tick();
      check("sb_i_drained", exp_i.size(), 64'd0);
      check("sb_d_drained", exp_d.size(), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
